// File: rtl/park_gate_scheduler_pkg.sv
// park_pkg: shared FSM state type and hour-dependent public capacity split.
package park_pkg;
  typedef enum logic [1:0] {IDLE, DECIDE, OPEN} state_t;
  localparam int PEAK_START = 8;
  localparam int RAMP_START = 13;
  localparam int RAMP_END   = 15;
  localparam int CAP_PEAK   = 200;
  localparam int CAP_STEP   = 50;
  localparam int CAP_OFF    = 500;
  function automatic logic [15:0] pub_capacity(input logic [4:0] hour);
    int h;
    h = int'(hour);
    return (h >= PEAK_START && h < RAMP_START) ? 16'(CAP_PEAK) :
           (h >= RAMP_START && h <= RAMP_END) ? 16'(CAP_PEAK + (h - (RAMP_START - 1)) * CAP_STEP) :
           16'(CAP_OFF);
  endfunction
endpackage

// File: rtl/park_gate_scheduler_rr_arbiter.sv
// park_rr_arbiter: round-robin pick of the first requester at or after the pointer.
module park_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx
);
  int w_j;
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = (int'(i_ptr) + k) % N;
      if (i_req[w_j]) begin
        o_grant = N'(1) << w_j;
        o_idx   = IW'(w_j);
      end
    end
  end
endmodule

// File: rtl/park_gate_scheduler.sv
// park_gate_scheduler: serialises lane requests, checks capacity, tracks occupancy, drives barriers.
module park_gate_scheduler
  import park_pkg::*;
#(
  parameter int NUM_LANES   = 4,
  parameter int TOTAL_CAP   = 700,
  parameter int GATE_CYCLES = 8,
  parameter int CNT_W       = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4:0]              hour,
  input  logic [NUM_LANES-1:0]    req_valid,
  input  logic [NUM_LANES-1:0]    req_is_exit,
  input  logic [NUM_LANES-1:0]    req_is_uni,
  output logic [NUM_LANES-1:0]    req_ready,
  output logic                    resp_valid,
  output logic                    resp_accept,
  output logic [2:0]              resp_lane,
  output logic [NUM_LANES-1:0]    gate_open,
  output logic [CNT_W-1:0]        uni_parked,
  output logic [CNT_W-1:0]        pub_parked,
  output logic signed [CNT_W:0]   uni_vacant,
  output logic signed [CNT_W:0]   pub_vacant,
  output logic                    busy
);
  localparam int LW = $clog2(NUM_LANES);
  localparam int TW = $clog2(GATE_CYCLES + 1);
  state_t                r_state, w_next;
  logic [LW-1:0]         r_ptr, r_lane, w_idx;
  logic                  r_exit, r_uni, w_accept;
  logic [TW-1:0]         r_timer;
  logic [CNT_W-1:0]      r_uni_cnt, r_pub_cnt, w_cnt;
  logic [NUM_LANES-1:0]  w_grant, w_onehot;
  logic [CNT_W:0]        w_pub_cap, w_uni_cap;
  logic signed [CNT_W:0] w_vac;

  park_rr_arbiter #(.N(NUM_LANES), .IW(LW)) u_arb (
    .i_req  (req_valid),
    .i_ptr  (r_ptr),
    .o_grant(w_grant),
    .o_idx  (w_idx)
  );

  assign w_pub_cap  = (CNT_W+1)'(pub_capacity(hour));
  assign w_uni_cap  = (CNT_W+1)'(TOTAL_CAP) - w_pub_cap;
  assign uni_vacant = w_uni_cap - {1'b0, r_uni_cnt};
  assign pub_vacant = w_pub_cap - {1'b0, r_pub_cnt};
  assign w_cnt      = r_uni ? r_uni_cnt : r_pub_cnt;
  assign w_vac      = r_uni ? uni_vacant : pub_vacant;
  assign w_accept   = r_exit ? (w_cnt != '0) : (w_vac > 0 && w_cnt != '1);
  assign w_onehot   = NUM_LANES'(1) << r_lane;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_lane    <= '0;
      r_exit    <= 1'b0;
      r_uni     <= 1'b0;
      r_timer   <= '0;
      r_uni_cnt <= '0;
      r_pub_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && |w_grant) begin
        r_lane <= w_idx;
        r_exit <= req_is_exit[w_idx];
        r_uni  <= req_is_uni[w_idx];
      end
      if (r_state == DECIDE) begin
        r_ptr <= (r_lane == LW'(NUM_LANES - 1)) ? '0 : r_lane + 1'b1;
        if (w_accept) begin
          r_timer <= TW'(GATE_CYCLES - 1);
          if (r_uni) r_uni_cnt <= r_exit ? r_uni_cnt - 1'b1 : r_uni_cnt + 1'b1;
          else       r_pub_cnt <= r_exit ? r_pub_cnt - 1'b1 : r_pub_cnt + 1'b1;
        end
      end
      if (r_state == OPEN && r_timer != '0) r_timer <= r_timer - 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = |w_grant ? DECIDE : IDLE;
      DECIDE:  w_next = w_accept ? OPEN : IDLE;
      OPEN:    w_next = (r_timer == '0) ? IDLE : OPEN;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = (r_state == DECIDE) ? w_onehot : '0;
    gate_open   = (r_state == OPEN) ? w_onehot : '0;
    resp_valid  = r_state == DECIDE;
    resp_accept = r_state == DECIDE && w_accept;
    resp_lane   = 3'(r_lane);
    uni_parked  = r_uni_cnt;
    pub_parked  = r_pub_cnt;
    busy        = r_state != IDLE;
  end
endmodule
